alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Parametrised, registered ALU operand-B selector for the multicycle datapath. It selects one of N_SRC operand sources and applies a per-request transform: pass-through, shift-left, 16-bit sign-extend, or sign-extend-then-shift for branch offsets. The result is captured in a one-deep valid/ready output register. A per-request hold counter keeps the operand stable for the extra cycles a multi-cycle ALU operation (mult/div) needs. It sits between the register-file/immediate sources and ALU input B.

## Interface
Parameters:
- DATA_W, 32, operand width; must be ≥ 17
- N_SRC, 4, number of operand sources; must be ≥ 2
- SEL_W, 2, select width; must satisfy 2^SEL_W ≥ N_SRC
- SHIFT_AMT, 2, left-shift amount for modes 01/11; must be < DATA_W
- HOLD_W, 6, hold-counter width; maximum hold is 2^HOLD_W − 1 cycles

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- src_bus  input  N_SRC*DATA_W  flattened sources; source k occupies bits [k*DATA_W +: DATA_W]
- in_valid  input  1  request present
- in_ready  output  1  stage can accept a request this cycle
- in_sel  input  SEL_W  source index
- in_mode  input  2  00 pass, 01 shl, 10 sext16, 11 sext16+shl
- in_hold  input  HOLD_W  extra cycles the result must be held before it can be popped
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts out_data
- out_data  output  DATA_W  registered operand
- out_err  output  1  captured request had in_sel ≥ N_SRC
- busy  output  1  hold counter is nonzero

## Operation
- Transform of selected source s:
  - mode 00: s
  - mode 01: s << SHIFT_AMT, zero fill, truncated to DATA_W
  - mode 10: {replicate s[15]} , s[15:0]
  - mode 11: (sext16(s)) << SHIFT_AMT, truncated
- Invalid select: in_sel ≥ N_SRC gives data 0 and err 1; mode is ignored. For a valid select, err is 0.
- Accept: in_valid && in_ready. On accept, the following are loaded: out_data ← transform, out_err ← err, cnt ← in_hold, out_valid ← 1.
- Pop: out_valid && out_ready && cnt == 0.
- in_ready = !out_valid || (out_ready && cnt == 0). This is combinational from out_ready and from state; it never depends on in_valid.
- Simultaneous pop and accept in the same cycle: the new request is loaded and out_valid stays 1. This gives full throughput of one operand per cycle when in_hold = 0.
- Pop without accept: out_valid ← 0. out_data and out_err keep their last values but are don't-care.
- Hold counter:
  - cnt decrements by 1 every cycle it is nonzero, regardless of out_ready.
  - While cnt ≠ 0, out_data is frozen and both pop and accept are blocked.
  - out_ready asserted during a hold is ignored and does not queue a pop.
- busy = (cnt ≠ 0), taken directly from the register.
- States (implicit):
  - EMPTY: out_valid = 0
  - HOLD: out_valid = 1, cnt ≠ 0
  - FULL: out_valid = 1, cnt = 0
- State transitions:
  - EMPTY → HOLD or FULL on accept, depending on in_hold.
  - HOLD → FULL when cnt reaches 0.
  - FULL → EMPTY on pop without accept.
  - FULL → FULL or HOLD on pop with accept.
- src_bus is sampled only on the accept edge. Later source changes do not affect out_data.

## Timing
- Reset (asynchronous, takes effect immediately): out_valid = 0, out_data = 0, out_err = 0, cnt = 0, busy = 0, in_ready = 1.
- Reset asserted mid-hold or mid-transfer drops the pending operand. The first accept after reset release is on the first rising edge with reset low.
- Latency: a request accepted at edge N appears on out_data/out_valid after edge N. It can first be popped in the same cycle if in_hold = 0, or H cycles later if in_hold = H.
- With in_hold = H: busy is high for exactly H cycles after the accept edge. The earliest pop is in the cycle where cnt = 0, i.e. H cycles after the accept edge.
- in_hold = 0 with out_ready held high: one accept and one pop every cycle, with no bubbles.

## Test plan
- Reset mid-hold:
  - Stimulus: accept with in_hold = 10, then pulse reset 3 cycles later.
  - Required: out_valid = 0, busy = 0 and in_ready = 1 immediately, without waiting for clk; out_data = 0.
- Transforms:
  - Stimulus: src1 = 0x0000_8001. Send mode 00, 01, 10, 11 with SHIFT_AMT = 2.
  - Required: out_data = 0x0000_8001, 0x0002_0004, 0xFFFF_8001, 0xFFFE_0004 respectively; out_err = 0 for all.
- Invalid select:
  - Stimulus: N_SRC = 3, in_sel = 3, mode 10, src values nonzero.
  - Required: out_data = 0, out_err = 1.
  - Then a valid request: out_err returns to 0.
- Back-to-back throughput:
  - Stimulus: 8 requests with in_hold = 0 and out_ready = 1 throughout.
  - Required: in_ready stays 1, and 8 pops occur on 8 consecutive cycles in order.
- Hold:
  - Stimulus: accept with in_hold = 5 from src0 = 0xA5A5_0000. Keep out_ready = 1, change src0, and present a second in_valid request.
  - Required: busy high for exactly 5 cycles; out_data stays 0xA5A5_0000; in_ready = 0 and no pop during those cycles. The pop and the second accept both occur in cycle 5.
- Backpressure:
  - Stimulus: out_ready = 0 for 4 cycles with in_valid = 1.
  - Required: in_ready = 0 and out_data stable for all 4 cycles. When out_ready rises, the pop and the next accept occur in the same cycle.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ALU operand-B selector: picks one of N_SRC sources, applies pass/shl/sext16/sext16+shl,
// and registers the result in a one-deep valid/ready slot with an optional per-request hold.
module alu_operand_stage #(
  parameter int DATA_W    = 32,
  parameter int N_SRC     = 4,
  parameter int SEL_W     = 2,
  parameter int SHIFT_AMT = 2,
  parameter int HOLD_W    = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SRC*DATA_W-1:0] src_bus,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [1:0]              in_mode,
  input  logic [HOLD_W-1:0]       in_hold,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_err,
  output logic                    busy
);

  logic [HOLD_W-1:0] cnt;
  logic [DATA_W-1:0] sel_src;
  logic [DATA_W-1:0] sext_src;
  logic [DATA_W-1:0] xform;
  logic              sel_err;
  logic              hold_done;
  logic              accept;
  logic              pop;

  always_comb begin
    sel_src = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (in_sel == SEL_W'(k)) sel_src = src_bus[k*DATA_W +: DATA_W];
    end
  end

  assign sel_err  = (int'(in_sel) >= N_SRC);
  assign sext_src = {{(DATA_W-16){sel_src[15]}}, sel_src[15:0]};

  // An out-of-range select forces zero data regardless of mode.
  always_comb begin
    xform = '0;
    if (!sel_err) begin
      case (in_mode)
        2'b00:   xform = sel_src;
        2'b01:   xform = sel_src << SHIFT_AMT;
        2'b10:   xform = sext_src;
        default: xform = sext_src << SHIFT_AMT;
      endcase
    end
  end

  assign hold_done = (cnt == '0);
  assign in_ready  = !out_valid || (out_ready && hold_done);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready && hold_done;
  assign busy      = !hold_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      // Accept implies cnt == 0, so loading the new hold never collides with a decrement.
      out_valid <= 1'b1;
      out_data  <= xform;
      out_err   <= sel_err;
      cnt       <= in_hold;
    end else begin
      if (!hold_done) cnt <= cnt - 1'b1;
      if (pop) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: transform table plus reset, throughput, hold and backpressure sequences.
module tb_alu_operand_stage;
  localparam int DATA_W = 32;
  localparam int N_SRC  = 3;
  localparam int SEL_W  = 2;
  localparam int HOLD_W = 6;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_SRC*DATA_W-1:0] src_bus;
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        in_sel;
  logic [1:0]              in_mode;
  logic [HOLD_W-1:0]       in_hold;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic                    out_err;
  logic                    busy;

  logic [31:0] src0, src1, src2;
  assign src_bus = {src2, src1, src0};

  int total = 0;
  int bad   = 0;

  alu_operand_stage #(
    .DATA_W(DATA_W), .N_SRC(N_SRC), .SEL_W(SEL_W), .SHIFT_AMT(2), .HOLD_W(HOLD_W)
  ) dut (
    .clk(clk), .reset(reset), .src_bus(src_bus),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_mode(in_mode),
    .in_hold(in_hold), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Advance to the next rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  mode;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];
  int busy_cycles;

  initial begin
    vecs[0] = '{2'd1, 2'b00, 32'h0000_8001, 1'b0};
    vecs[1] = '{2'd1, 2'b01, 32'h0002_0004, 1'b0};
    vecs[2] = '{2'd1, 2'b10, 32'hFFFF_8001, 1'b0};
    vecs[3] = '{2'd1, 2'b11, 32'hFFFE_0004, 1'b0};
    vecs[4] = '{2'd3, 2'b10, 32'h0000_0000, 1'b1};
    vecs[5] = '{2'd2, 2'b10, 32'h0000_7FFF, 1'b0};
    vecs[6] = '{2'd0, 2'b10, 32'hFFFF_F00F, 1'b0};
    vecs[7] = '{2'd0, 2'b01, 32'h48D3_C03C, 1'b0};
    vecs[8] = '{2'd2, 2'b11, 32'h0001_FFFC, 1'b0};
    vecs[9] = '{2'd3, 2'b00, 32'h0000_0000, 1'b1};

    src0 = 32'h1234_F00F; src1 = 32'h0000_8001; src2 = 32'h0000_7FFF;
    in_valid = 0; in_sel = 0; in_mode = 0; in_hold = 0; out_ready = 0;
    reset = 1;
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", 32'(out_err), 0);
    step(); step();
    reset = 0;
    step();

    // Transform / select table, one request at a time.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_sel = vecs[i].sel; in_mode = vecs[i].mode; in_hold = 0; out_ready = 0;
      step();
      in_valid = 0;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), 32'(out_err), 32'(vecs[i].exp_err));
      out_ready = 1;
      step();
      out_ready = 0;
      chk($sformatf("vec%0d_popped", i), 32'(out_valid), 0);
    end
    // A valid request after an invalid one clears out_err.
    in_valid = 1; in_sel = 1; in_mode = 0;
    step();
    in_valid = 0;
    chk("err_clear", 32'(out_err), 0);
    chk("err_clear_data", out_data, 32'h0000_8001);
    out_ready = 1; step(); out_ready = 0;

    // Reset asserted mid-hold.
    in_valid = 1; in_sel = 0; in_mode = 0; in_hold = 10;
    step();
    in_valid = 0; in_hold = 0;
    step(); step(); step();
    chk("pre_rst_busy", 32'(busy), 1);
    reset = 1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_out_data", out_data, 0);
    step();
    reset = 0;
    step();

    // Back-to-back throughput: item i carries src1 = 0x100+i.
    out_ready = 1; in_sel = 1; in_mode = 0; in_hold = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        in_valid = 1; src1 = 32'h100 + i;
      end else begin
        in_valid = 0;
      end
      if (i < 9) chk($sformatf("b2b_in_ready%0d", i), 32'(in_ready), 1);
      if (i >= 1 && i <= 8) begin
        chk($sformatf("b2b_valid%0d", i), 32'(out_valid), 1);
        chk($sformatf("b2b_data%0d", i), out_data, 32'h100 + i - 1);
      end
      step();
    end
    chk("b2b_drained", 32'(out_valid), 0);
    in_valid = 0; src1 = 32'h0000_8001;

    // Hold of 5 with out_ready high and a second request waiting.
    src0 = 32'hA5A5_0000; in_valid = 1; in_sel = 0; in_mode = 0; in_hold = 5; out_ready = 1;
    step();
    src0 = 32'h1111_1111; in_mode = 2'b01; in_hold = 0;
    busy_cycles = 0;
    for (int c = 1; c <= 5; c++) begin
      if (busy) busy_cycles++;
      chk($sformatf("hold_in_ready%0d", c), 32'(in_ready), 0);
      chk($sformatf("hold_data%0d", c), out_data, 32'hA5A5_0000);
      chk($sformatf("hold_valid%0d", c), 32'(out_valid), 1);
      step();
    end
    chk("hold_busy_cycles", 32'(busy_cycles), 5);
    chk("hold_busy_end", 32'(busy), 0);
    chk("hold_ready_end", 32'(in_ready), 1);
    chk("hold_data_end", out_data, 32'hA5A5_0000);
    step();
    in_valid = 0;
    chk("hold_next_data", out_data, 32'h4444_4444);
    chk("hold_next_valid", 32'(out_valid), 1);
    step();
    chk("hold_next_popped", 32'(out_valid), 0);

    // Backpressure: out_ready low for 4 cycles with a request pending.
    out_ready = 0; in_valid = 1; in_sel = 2; in_mode = 0; in_hold = 0;
    step();
    in_sel = 1; in_mode = 2'b10;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("bp_in_ready%0d", c), 32'(in_ready), 0);
      chk($sformatf("bp_data%0d", c), out_data, 32'h0000_7FFF);
      step();
    end
    out_ready = 1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 1);
    step();
    in_valid = 0;
    chk("bp_next_data", out_data, 32'hFFFF_8001);
    chk("bp_next_valid", 32'(out_valid), 1);
    step();
    chk("bp_drained", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
